adc_trig_capture: RTL and testbench

- Downstream consumer of the 14-bit scope ADC sample stream inside top.
- Arms on request, keeps a circular pre-trigger history, and detects a level crossing on the signed sample.
- After the trigger it fills the remaining buffer with post-trigger samples, then holds the record for readout by the host/ILA side.
- Readout is time-ordered: the oldest sample is at address 0.

---
 rtl/adc_trig_capture.sv | 162 ++++++++++++++++
 tb/tb_adc_trig_capture.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// Triggered capture of the signed 14-bit ADC stream: circular pre-trigger history,
// level/forced trigger, post-trigger fill, then a time-ordered record held for readout.
module adc_trig_capture #(
    parameter int DEPTH = 1024,
    parameter int PRE   = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          mclk,
    input  logic          ext_rst,
    input  logic [13:0]   adc_data,
    input  logic          adc_valid,
    input  logic          arm,
    input  logic          abort,
    input  logic          force_trig,
    input  logic [13:0]   trig_level,
    input  logic          trig_edge,
    input  logic [AW-1:0] rd_addr,
    output logic [13:0]   rd_data,
    output logic          busy,
    output logic          triggered,
    output logic          done,
    output logic [AW-1:0] trig_addr
);

    localparam int DATA_W = 14;
    localparam logic [AW-1:0] PRE_A     = AW'(PRE);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE - 2);

    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_WAIT, S_POST, S_DONE} state_t;

    state_t                   state_q;
    logic [AW-1:0]            wp_q;
    logic [AW-1:0]            cnt_q;
    logic [AW-1:0]            trig_addr_q;
    logic                     prev_valid_q;
    logic                     force_pend_q;
    logic                     busy_q;
    logic                     triggered_q;
    logic                     done_q;
    logic signed [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0]        rd_data_q;
    logic [DATA_W-1:0]        mem [DEPTH];

    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W-1:0] lvl;
    logic                     we;
    logic                     level_hit;
    logic [AW-1:0]            rd_phys;

    function automatic logic crossed(input logic signed [DATA_W-1:0] p,
                                     input logic signed [DATA_W-1:0] c,
                                     input logic signed [DATA_W-1:0] l,
                                     input logic                     falling);
        if (falling) return (p > l) && (c <= l);
        return (p < l) && (c >= l);
    endfunction

    assign cur       = $signed(adc_data);
    assign lvl       = $signed(trig_level);
    assign level_hit = prev_valid_q && crossed(prev_q, cur, lvl, trig_edge);
    assign we        = ext_rst && adc_valid && busy_q;
    // Oldest sample of the record sits PRE entries before the trigger sample.
    assign rd_phys   = trig_addr_q - PRE_A + rd_addr;

    always_ff @(posedge mclk) begin
        if (we) begin
            mem[wp_q] <= adc_data;
            prev_q    <= cur;
        end
    end

    always_ff @(posedge mclk) begin
        if (!ext_rst) rd_data_q <= '0;
        else          rd_data_q <= mem[rd_phys];
    end

    always_ff @(posedge mclk) begin
        if (!ext_rst) begin
            state_q      <= S_IDLE;
            wp_q         <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm && !abort) begin
                        state_q      <= S_PREFILL;
                        wp_q         <= '0;
                        cnt_q        <= '0;
                        prev_valid_q <= 1'b0;
                        force_pend_q <= 1'b0;
                        triggered_q  <= 1'b0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                default: begin
                    if (abort) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b0;
                        force_pend_q <= 1'b0;
                    end else begin
                        if (adc_valid) begin
                            wp_q         <= wp_q + 1'b1;
                            prev_valid_q <= 1'b1;
                        end
                        case (state_q)
                            S_PREFILL: begin
                                if (adc_valid) begin
                                    if (cnt_q == PRE_LAST) begin
                                        state_q <= S_WAIT;
                                        cnt_q   <= '0;
                                    end else begin
                                        cnt_q <= cnt_q + 1'b1;
                                    end
                                end
                            end
                            S_WAIT: begin
                                // A forced trigger and a level crossing on the same sample collapse into one.
                                if (adc_valid && (level_hit || force_pend_q || force_trig)) begin
                                    state_q      <= S_POST;
                                    cnt_q        <= '0;
                                    trig_addr_q  <= wp_q;
                                    triggered_q  <= 1'b1;
                                    force_pend_q <= 1'b0;
                                end else if (force_trig) begin
                                    force_pend_q <= 1'b1;
                                end
                            end
                            S_POST: begin
                                if (adc_valid) begin
                                    if (cnt_q == POST_LAST) begin
                                        state_q <= S_DONE;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end else begin
                                        cnt_q <= cnt_q + 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed scoreboard bench for adc_trig_capture with DEPTH=16, PRE=4.
module tb_adc_trig_capture;

    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int AW    = 4;

    logic          mclk = 1'b0;
    logic          ext_rst;
    logic [13:0]   adc_data;
    logic          adc_valid;
    logic          arm;
    logic          abort;
    logic          force_trig;
    logic [13:0]   trig_level;
    logic          trig_edge;
    logic [AW-1:0] rd_addr;
    logic [13:0]   rd_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;

    always #4 mclk = ~mclk;

    adc_trig_capture #(.DEPTH(DEPTH), .PRE(PRE), .AW(AW)) dut (
        .mclk(mclk), .ext_rst(ext_rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .arm(arm), .abort(abort), .force_trig(force_trig), .trig_level(trig_level),
        .trig_edge(trig_edge), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .triggered(triggered), .done(done), .trig_addr(trig_addr)
    );

    typedef struct {
        int    sel;
        int    exp;
        string name;
    } st_t;

    st_t  st_q[$];
    st_t  rd_q[$];
    int   seq[$];
    int   rexp[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rd_issue  = 1'b0;
    logic rd_vld_tb = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int pick(input int sel);
        case (sel)
            0:       return int'(busy);
            1:       return int'(triggered);
            2:       return int'(done);
            3:       return int'(trig_addr);
            4:       return int'($signed(rd_data));
            default: return -99999;
        endcase
    endfunction

    always @(posedge mclk) rd_vld_tb <= rd_issue;

    // Monitor: pops status expectations and read results on the falling edge.
    always @(negedge mclk) begin
        st_t e;
        while (st_q.size() > 0) begin
            e = st_q.pop_front();
            check(e.name, pick(e.sel), e.exp);
        end
        if (rd_vld_tb) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_underflow: got read data %0d with no expected entry", $signed(rd_data));
            end else begin
                e = rd_q.pop_front();
                check(e.name, int'($signed(rd_data)), e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_st(input int sel, input int exp, input string name);
        st_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        st_q.push_back(e);
    endtask

    task automatic smp(input int v);
        adc_data  = 14'(v);
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        expect_st(0, 1, "busy_after_arm");
        expect_st(1, 0, "triggered_clr_arm");
        expect_st(2, 0, "done_clr_arm");
    endtask

    task automatic run_capture(input int tidx, input int taddr, input bit gap);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == seq.size() - 1) expect_st(2, 0, "done_before_last");
            smp(seq[i]);
            if (i == tidx - 1) expect_st(1, 0, "no_trig_early");
            if (i == tidx) begin
                expect_st(1, 1, "triggered");
                expect_st(3, taddr, "trig_addr");
            end
            if (i == seq.size() - 1) begin
                expect_st(2, 1, "done_after_last");
                expect_st(0, 0, "busy_after_last");
            end
            if (gap) idle(1);
        end
    endtask

    task automatic read_all();
        st_t e;
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr  = AW'(k);
            rd_issue = 1'b1;
            e.sel    = 4;
            e.exp    = rexp[k];
            e.name   = $sformatf("rd_k%0d", k);
            rd_q.push_back(e);
            tick();
        end
        rd_issue = 1'b0;
        idle(2);
    endtask

    initial begin
        ext_rst    = 1'b0;
        adc_data   = '0;
        adc_valid  = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
        trig_level = '0;
        trig_edge  = 1'b0;
        rd_addr    = '0;
        idle(2);
        expect_st(0, 0, "rst_busy");
        expect_st(1, 0, "rst_triggered");
        expect_st(2, 0, "rst_done");
        expect_st(3, 0, "rst_trig_addr");
        expect_st(4, 0, "rst_rd_data");
        ext_rst = 1'b1;
        idle(1);

        // Rising ramp through zero
        trig_level = 14'sd0;
        trig_edge  = 1'b0;
        do_arm();
        seq = {};
        for (int v = -20; v <= 11; v++) seq.push_back(v);
        run_capture(20, 4, 1'b0);
        smp(12); smp(13); smp(14);
        expect_st(2, 1, "done_hold");
        rexp = {};
        for (int k = 0; k < DEPTH; k++) rexp.push_back(k - 4);
        read_all();

        // Falling edge; the PREFILL crossing 100->10 must not trigger
        trig_level = 14'sd20;
        trig_edge  = 1'b1;
        do_arm();
        seq = {100, 10, 100, 100, 100, 100, 100, 100, 100, 50, -10};
        for (int v = 200; v <= 210; v++) seq.push_back(v);
        run_capture(10, 10, 1'b0);
        rexp = {100, 100, 100, 50, -10};
        for (int v = 200; v <= 210; v++) rexp.push_back(v);
        read_all();

        // Forced trigger, level unreachable
        trig_level = 14'sd1000;
        trig_edge  = 1'b0;
        do_arm();
        force_trig = 1'b1;
        smp(5); smp(5); smp(5); smp(5);
        smp(5); smp(5); smp(5);
        expect_st(1, 0, "no_force_in_prefill");
        force_trig = 1'b1;
        idle(1);
        expect_st(1, 0, "force_pending_only");
        seq = {};
        for (int i = 0; i < 12; i++) seq.push_back(5);
        run_capture(0, 7, 1'b0);
        rexp = {};
        for (int k = 0; k < DEPTH; k++) rexp.push_back(5);
        read_all();

        // Wrap-around: 37 WAIT samples before the crossing
        trig_level = 14'sd0;
        do_arm();
        seq = {-50, -50, -50, -50};
        for (int v = -37; v <= -1; v++) seq.push_back(v);
        for (int v = 7; v <= 18; v++) seq.push_back(v);
        run_capture(41, 9, 1'b0);
        rexp = {-4, -3, -2, -1};
        for (int v = 7; v <= 18; v++) rexp.push_back(v);
        read_all();

        // Gapped valid, arm ignored mid-POST, then abort
        do_arm();
        seq = {-8, -7, -6, -5, -4, -3, 2, 3, 4};
        for (int i = 0; i < seq.size(); i++) begin
            smp(seq[i]);
            if (i == 6) begin
                expect_st(1, 1, "gap_triggered");
                expect_st(3, 6, "gap_trig_addr");
            end
            idle(1);
        end
        arm = 1'b1;
        idle(1);
        expect_st(0, 1, "arm_ignored_busy");
        expect_st(1, 1, "arm_ignored_trig");
        expect_st(2, 0, "arm_ignored_done");
        smp(5);
        abort = 1'b1;
        idle(1);
        expect_st(0, 0, "abort_busy");
        expect_st(2, 0, "abort_done");
        expect_st(1, 1, "abort_trig_kept");
        smp(9);
        expect_st(0, 0, "abort_stays_idle");
        do_arm();
        seq = {-1, -1, -1, -1};
        for (int v = 3; v <= 14; v++) seq.push_back(v);
        run_capture(4, 4, 1'b1);
        rexp = {-1, -1, -1, -1};
        for (int v = 3; v <= 14; v++) rexp.push_back(v);
        read_all();

        // Reset while waiting for a trigger
        do_arm();
        for (int i = 0; i < 6; i++) smp(-1);
        rd_addr = 4'd5;
        idle(1);
        expect_st(4, -1, "rd_before_rst");
        expect_st(0, 1, "busy_before_rst");
        ext_rst = 1'b0;
        tick();
        expect_st(0, 0, "wrst_busy");
        expect_st(1, 0, "wrst_triggered");
        expect_st(2, 0, "wrst_done");
        expect_st(3, 0, "wrst_trig_addr");
        expect_st(4, 0, "wrst_rd_data");
        ext_rst    = 1'b1;
        force_trig = 1'b1;
        smp(5);
        smp(5);
        expect_st(1, 0, "force_after_rst");
        expect_st(0, 0, "idle_after_rst");
        idle(2);

        n_chk++;
        if (st_q.size() == 0 && rd_q.size() == 0) n_pass++;
        else $display("FAIL leftover: got %0d status and %0d read entries pending, expected 0", st_q.size(), rd_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
